// File: rtl/irq_pkg.sv
// Shared encodings and control-word decode for the interrupt sequencer.
package irq_pkg;

  // Default ISR entry point.
  localparam logic [31:0] DEFAULT_VECTOR_ADDR = 32'h0000_0018;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_VECTOR = 3'd2,
    ST_ISR    = 3'd3,
    ST_RETURN = 3'd4
  } irq_state_e;

  // PC source select codes.
  typedef enum logic [1:0] {
    NPC_SEQ   = 2'b00,
    NPC_VEC   = 2'b01,
    NPC_SAVED = 2'b10
  } npc_sel_e;

  // Registered pipeline control word.
  typedef struct packed {
    logic     stall_if;
    logic     flush;
    logic     pc_wr;
    npc_sel_e npc_sel;
    logic     cpsr_wr;
    logic     in_isr;
    logic     irq_ack;
  } irq_ctl_t;

  // Control outputs implied by being in a given state.
  function automatic irq_ctl_t ctl_decode(input irq_state_e s);
    irq_ctl_t c;
    c.stall_if = 1'b0;
    c.flush    = 1'b0;
    c.pc_wr    = 1'b0;
    c.npc_sel  = NPC_SEQ;
    c.cpsr_wr  = 1'b0;
    c.in_isr   = 1'b0;
    c.irq_ack  = 1'b0;
    case (s)
      ST_DRAIN: begin
        c.stall_if = 1'b1;
      end
      ST_VECTOR: begin
        c.flush   = 1'b1;
        c.pc_wr   = 1'b1;
        c.irq_ack = 1'b1;
        c.npc_sel = NPC_VEC;
      end
      ST_ISR: begin
        c.in_isr = 1'b1;
      end
      ST_RETURN: begin
        c.flush   = 1'b1;
        c.pc_wr   = 1'b1;
        c.cpsr_wr = 1'b1;
        c.npc_sel = NPC_SAVED;
      end
      default: begin
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/irq_sequencer_sync_2ff.sv
// Two-flop synchronizer; both stages clear to 0 on reset.
module sync_2ff (
  input  logic CLK,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage metastability filter.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt entry/exit sequencer: drains the pipeline, vectors to the ISR,
// and restores PC and flags on return. All outputs are registered.
module irq_sequencer
  import irq_pkg::*;
#(
  parameter logic [31:0] VECTOR_ADDR  = DEFAULT_VECTOR_ADDR,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        irq_n,
  input  logic        irq_en,
  input  logic        hold_ex,
  input  logic        ret_ex,
  input  logic [31:0] pc_resume,
  input  logic [3:0]  cpsr_in,
  output logic        stall_if,
  output logic        flush,
  output logic        pc_wr,
  output logic [1:0]  npc_sel,
  output logic [31:0] vec_addr,
  output logic [31:0] saved_pc,
  output logic        cpsr_wr,
  output logic [3:0]  cpsr_restore,
  output logic        in_isr,
  output logic        irq_ack
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  irq_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  irq_ctl_t    ctl_q, ctl_d;
  logic [31:0] saved_pc_q;
  logic [3:0]  cpsr_q;
  logic        capture;
  logic        irq_req;

  // Synchronizing the inverted pin makes a reset-cleared flop mean "no request".
  sync_2ff u_sync (
    .CLK (CLK),
    .rst (rst),
    .d   (~irq_n),
    .q   (irq_req)
  );

  // Next-state, drain counter and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (irq_req && irq_en) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        // The request is latched by being here; irq_n/irq_en are not looked at.
        if (!hold_ex) begin
          if (cnt_q <= 4'd1) begin
            state_d = ST_VECTOR;
            cnt_d   = '0;
            capture = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      ST_VECTOR: begin
        state_d = ST_ISR;
      end
      ST_ISR: begin
        if (ret_ex) begin
          state_d = ST_RETURN;
        end
      end
      ST_RETURN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Outputs are decoded from the next state so they are flops, valid
    // for the whole cycle the FSM spends in that state.
    ctl_d = ctl_decode(state_d);
  end

  // State, counter and control-word registers.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ctl_q   <= ctl_decode(ST_IDLE);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
    end
  end

  // Resume context, captured on the DRAIN->VECTOR edge and held until the next one.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      saved_pc_q <= '0;
      cpsr_q     <= '0;
    end else if (capture) begin
      saved_pc_q <= pc_resume;
      cpsr_q     <= cpsr_in;
    end
  end

  assign stall_if     = ctl_q.stall_if;
  assign flush        = ctl_q.flush;
  assign pc_wr        = ctl_q.pc_wr;
  assign npc_sel      = ctl_q.npc_sel;
  assign cpsr_wr      = ctl_q.cpsr_wr;
  assign in_isr       = ctl_q.in_isr;
  assign irq_ack      = ctl_q.irq_ack;
  assign vec_addr     = VECTOR_ADDR;
  assign saved_pc     = saved_pc_q;
  assign cpsr_restore = cpsr_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer with hand-computed expected values.
module tb_irq_sequencer;

  logic        CLK;
  logic        rst;
  logic        irq_n;
  logic        irq_en;
  logic        hold_ex;
  logic        ret_ex;
  logic [31:0] pc_resume;
  logic [3:0]  cpsr_in;
  logic        stall_if;
  logic        flush;
  logic        pc_wr;
  logic [1:0]  npc_sel;
  logic [31:0] vec_addr;
  logic [31:0] saved_pc;
  logic        cpsr_wr;
  logic [3:0]  cpsr_restore;
  logic        in_isr;
  logic        irq_ack;

  int checks = 0;
  int errors = 0;

  // Control word {stall_if, flush, pc_wr, npc_sel[1:0], cpsr_wr, in_isr, irq_ack}
  localparam logic [7:0] C_IDLE   = 8'h00;
  localparam logic [7:0] C_DRAIN  = 8'h80;
  localparam logic [7:0] C_VECTOR = 8'h69;
  localparam logic [7:0] C_ISR    = 8'h02;
  localparam logic [7:0] C_RETURN = 8'h74;

  irq_sequencer #(
    .VECTOR_ADDR  (32'h0000_0018),
    .DRAIN_CYCLES (3)
  ) dut (
    .CLK          (CLK),
    .rst          (rst),
    .irq_n        (irq_n),
    .irq_en       (irq_en),
    .hold_ex      (hold_ex),
    .ret_ex       (ret_ex),
    .pc_resume    (pc_resume),
    .cpsr_in      (cpsr_in),
    .stall_if     (stall_if),
    .flush        (flush),
    .pc_wr        (pc_wr),
    .npc_sel      (npc_sel),
    .vec_addr     (vec_addr),
    .saved_pc     (saved_pc),
    .cpsr_wr      (cpsr_wr),
    .cpsr_restore (cpsr_restore),
    .in_isr       (in_isr),
    .irq_ack      (irq_ack)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {stall_if, flush, pc_wr, npc_sel, cpsr_wr, in_isr, irq_ack};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s ctl observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b0;
    irq_n     = 1'b1;
    irq_en    = 1'b0;
    hold_ex   = 1'b0;
    ret_ex    = 1'b0;
    pc_resume = 32'h0000_0100;
    cpsr_in   = 4'b0101;

    // Reset state
    tick();
    tick();
    chk_ctl("reset_ctl", C_IDLE);
    chk_val("reset_saved_pc", saved_pc, 32'h0);
    chk_val("reset_cpsr", {28'h0, cpsr_restore}, 32'h0);
    chk_val("vec_addr", vec_addr, 32'h0000_0018);
    rst = 1'b1;

    // Basic entry: irq_n low before edge 0
    irq_n  = 1'b0;
    irq_en = 1'b1;
    tick(); chk_ctl("entry_e0", C_IDLE);
    tick(); chk_ctl("entry_e1", C_IDLE);
    tick(); chk_ctl("entry_e2_drain", C_DRAIN);
    tick(); chk_ctl("entry_e3_drain", C_DRAIN);
    tick(); chk_ctl("entry_e4_drain", C_DRAIN);
    tick(); chk_ctl("entry_e5_vector", C_VECTOR);
    chk_val("entry_saved_pc", saved_pc, 32'h0000_0100);
    chk_val("entry_cpsr", {28'h0, cpsr_restore}, 32'h5);
    tick(); chk_ctl("entry_e6_isr", C_ISR);
    irq_n = 1'b1;
    tick(); chk_ctl("isr_hold1", C_ISR);
    tick(); chk_ctl("isr_hold2", C_ISR);
    ret_ex = 1'b1;
    tick(); chk_ctl("ret1_return", C_RETURN);
    chk_val("ret1_cpsr", {28'h0, cpsr_restore}, 32'h5);
    ret_ex = 1'b0;
    tick(); chk_ctl("ret1_idle", C_IDLE);

    // Masked: irq_en low keeps IDLE
    irq_en = 1'b0;
    irq_n  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); chk_ctl("masked_idle", C_IDLE);
    end
    irq_n = 1'b1;
    tick();
    tick();

    // Drain hold, ret_ex/irq_en/irq_n changes ignored during DRAIN
    irq_en    = 1'b1;
    pc_resume = 32'h0000_0040;
    cpsr_in   = 4'b1010;
    irq_n     = 1'b0;
    tick(); chk_ctl("hold_e0", C_IDLE);
    tick(); chk_ctl("hold_e1", C_IDLE);
    tick(); chk_ctl("hold_e2_drain", C_DRAIN);
    irq_n   = 1'b1;
    irq_en  = 1'b0;
    hold_ex = 1'b1;
    ret_ex  = 1'b1;
    tick(); chk_ctl("hold_e3_held", C_DRAIN);
    tick(); chk_ctl("hold_e4_held", C_DRAIN);
    hold_ex = 1'b0;
    ret_ex  = 1'b0;
    tick(); chk_ctl("hold_e5_drain", C_DRAIN);
    tick(); chk_ctl("hold_e6_drain", C_DRAIN);
    tick(); chk_ctl("hold_e7_vector", C_VECTOR);
    chk_val("hold_saved_pc", saved_pc, 32'h0000_0040);
    chk_val("hold_cpsr", {28'h0, cpsr_restore}, 32'hA);
    pc_resume = 32'h0000_0080;
    cpsr_in   = 4'b0000;
    tick(); chk_ctl("hold_e8_isr", C_ISR);
    chk_val("hold_saved_stable", saved_pc, 32'h0000_0040);

    // Nesting: second irq in ISR has no effect until after RETURN
    irq_en = 1'b1;
    irq_n  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_ctl("nest_isr", C_ISR);
    end
    ret_ex = 1'b1;
    tick(); chk_ctl("ret2_return", C_RETURN);
    chk_val("ret2_saved_pc", saved_pc, 32'h0000_0040);
    chk_val("ret2_cpsr", {28'h0, cpsr_restore}, 32'hA);
    ret_ex = 1'b0;
    tick(); chk_ctl("nest_idle_gap", C_IDLE);
    tick(); chk_ctl("nest_redrain", C_DRAIN);
    tick(); chk_ctl("nest_drain2", C_DRAIN);

    // Reset mid-DRAIN: immediate, and no vector after release with irq_n high
    irq_n = 1'b1;
    rst   = 1'b0;
    #1;
    chk_ctl("rst_mid_ctl", C_IDLE);
    chk_val("rst_mid_saved_pc", saved_pc, 32'h0);
    chk_val("rst_mid_cpsr", {28'h0, cpsr_restore}, 32'h0);
    tick(); chk_ctl("rst_held", C_IDLE);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(); chk_ctl("post_rst_idle", C_IDLE);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_sequencer.md
IRQ_SEQUENCER -- requirements
Module: irq_sequencer

Interface
REQ-001 SHALL have parameter VECTOR_ADDR, default 32'h0000_0018: ISR entry address driven on vec_addr.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3: pipeline-empty cycle count before vectoring (range 1..15).
REQ-003 SHALL have port CLK  input  1  pipeline clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port irq_n  input  1  external interrupt request, active-low, asynchronous to CLK.
REQ-006 SHALL have port irq_en  input  1  global interrupt enable.
REQ-007 SHALL have port hold_ex  input  1  branch resolving in EX or access in MEM; drain must wait.
REQ-008 SHALL have port ret_ex  input  1  return-from-interrupt instruction in EX.
REQ-009 SHALL have port pc_resume  input  32  PC of oldest unretired instruction.
REQ-010 SHALL have port cpsr_in  input  4  live NZCV flags.
REQ-011 SHALL have port stall_if  output  1  freeze fetch; no new instruction enters ID.
REQ-012 SHALL have port flush  output  1  squash IF/ID/EX stage registers.
REQ-013 SHALL have port pc_wr  output  1  PC load strobe.
REQ-014 SHALL have port npc_sel  output  2  PC source: 00 sequential, 01 vec_addr, 10 saved_pc.
REQ-015 SHALL have port vec_addr  output  32  constant VECTOR_ADDR.
REQ-016 SHALL have port saved_pc  output  32  captured resume PC.
REQ-017 SHALL have port cpsr_wr  output  1  restore strobe for flags.
REQ-018 SHALL have port cpsr_restore  output  4  captured NZCV.
REQ-019 SHALL have port in_isr  output  1  high while the handler executes.
REQ-020 SHALL have port irq_ack  output  1  one-cycle acknowledge to the interrupt source.

Function
REQ-021 SHALL pass irq_n through a 2-flop synchronizer; irq_req = inverted synchronized irq_n.
REQ-022 SHALL implement FSM states IDLE, DRAIN, VECTOR, ISR, RETURN; all outputs are registered state decodes.
REQ-023 SHALL transition IDLE->DRAIN when irq_req & irq_en; the request is latched, so irq_n deassertion during DRAIN does not abort.
REQ-024 SHALL in DRAIN assert stall_if, load a 4-bit counter with DRAIN_CYCLES on entry, decrement once per cycle with hold_ex low, and hold while hold_ex is high.
REQ-025 SHALL leave DRAIN for VECTOR on the edge where the counter reaches 0, capturing saved_pc<=pc_resume and cpsr_restore<=cpsr_in on that same edge.
REQ-026 SHALL in VECTOR (exactly 1 cycle) assert flush, pc_wr, irq_ack, npc_sel=01, then enter ISR.
REQ-027 SHALL in ISR assert in_isr only; irq_req is ignored (no nesting); ret_ex moves to RETURN.
REQ-028 SHALL in RETURN (exactly 1 cycle) assert flush, pc_wr, cpsr_wr, npc_sel=10, then enter IDLE.
REQ-029 SHALL ignore ret_ex in IDLE, DRAIN and VECTOR.
REQ-030 SHALL, if irq_req is still asserted on the RETURN->IDLE edge, re-enter DRAIN on the next edge (one IDLE cycle minimum).
REQ-031 SHALL, if irq_en falls during DRAIN, complete the sequence (enable sampled only in IDLE).
REQ-032 SHALL keep npc_sel=00 and pc_wr, flush, cpsr_wr, irq_ack low in IDLE, DRAIN and ISR.
REQ-033 SHALL hold saved_pc and cpsr_restore stable from capture until the next capture.

Reset
REQ-034 SHALL on rst low immediately force state IDLE, counter 0, synchronizer flops to 0 (no request), saved_pc 0, cpsr_restore 0, all strobes low, npc_sel 00, including mid-sequence.
REQ-035 SHALL require two CLK edges after rst release before an asserted irq_n can be observed.

Structure
REQ-036 SHALL place the state encoding, npc_sel codes and default VECTOR_ADDR in shared package irq_pkg.
REQ-037 SHALL instantiate one sub-module, sync_2ff, for the irq_n synchronizer.

Verification
REQ-038 SHALL test basic entry: irq_n low before edge 0, irq_en=1, hold_ex=0 -> DRAIN after edge 2; VECTOR after edge 5 with pc_wr=1, npc_sel=01, irq_ack=1; in_isr=1 after edge 6.
REQ-039 SHALL test drain hold: hold_ex high for 2 cycles inside DRAIN -> VECTOR delayed exactly 2 cycles; saved_pc equals pc_resume at exit (e.g. 32'h0000_0040).
REQ-040 SHALL test return: cpsr_in=4'b1010 at capture, later ret_ex=1 in ISR -> next cycle npc_sel=10, cpsr_wr=1, cpsr_restore=4'b1010, saved_pc=32'h40; then IDLE.
REQ-041 SHALL test masking/nesting: irq_en=0 with irq_n low -> stays IDLE; a second irq during ISR -> no effect until after RETURN, then DRAIN after one IDLE cycle.
REQ-042 SHALL test reset mid-DRAIN: rst low -> all outputs at reset values within the same cycle; no VECTOR follows after release unless irq_n is still low.
